multimode_ctrl: RTL and testbench
=================================

# multimode_ctrl

Parametrised top-level sequencer for the image pipeline. It generalises the two-lever mode controller to NUM_MODES modes, each either a single whole-frame pass or a row-by-row FETCH/CORE loop. It owns the row counter internally and adds a start-edge detector, abort, and a per-phase watchdog with an error state. It sits between the board switches/LEDs and the memory controller and preprocessor core.

## Interface
Parameters:
- NUM_MODES, 4, number of selectable modes (≥2)
- FRAME_MASK, 4'b0001, bit m = 1 → mode m is a whole-frame pass; 0 → row loop
- MAX_ROW, 360, rows per image
- MAX_COL, 540, columns per row
- BPP, 3, bytes per pixel
- LEN_W, 20, cnt_len_o width
- ROW_W, 10, row counter width
- TIMEOUT_CYC, 2**20, watchdog limit per running phase

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- mode_sel_i  in  NUM_MODES  lever bank; a mode is valid only when exactly one bit is set
- start_i  in  1  start push-button, level (edge detected internally)
- abort_i  in  1  abort request, level
- frame_done_i  in  1  whole-frame pass complete (1-cycle pulse)
- fetch_done_i  in  1  row fetch complete (pulse)
- core_done_i  in  1  row processing complete (pulse)
- mode_o  out  $clog2(NUM_MODES)  latched mode index
- armed_o  out  1  mode latched, awaiting start
- frame_run_o / fetch_run_o / core_run_o  out  1 each  phase enables
- cnt_len_o  out  LEN_W  transfer length for the active phase
- row_o  out  ROW_W  current row, for the 7-segment display
- led_idle_o  out  1  DONE indicator
- led_err_o  out  1  ERROR indicator
- state_o  out  3  state encoding, for debug

## Operation
- States: IDLE=0, ARMED=1, FRAME_RUN=2, FETCH=3, CORE=4, DONE=5, ERROR=6.
- start_rise = start_i & ~start_q, where start_q is a registered copy of start_i. Only start_rise advances the machine.
- IDLE: a valid one-hot mode_sel_i latches the mode index and moves to ARMED.
- ARMED:
  - start_rise moves to FRAME_RUN if FRAME_MASK[mode], otherwise to FETCH with row cleared to 0.
  - Without start_rise, a different valid one-hot selection re-latches the mode.
  - An invalid selection is ignored.
- FRAME_RUN: cnt_len_o = MAX_ROW*MAX_COL*BPP, so 583200 at the defaults. frame_done_i moves to DONE.
- FETCH: cnt_len_o = MAX_COL*BPP, so 1620. fetch_done_i moves to CORE.
- CORE:
  - core_done_i with row == MAX_ROW-1 moves to DONE; row holds.
  - core_done_i otherwise increments row and returns to FETCH.
- DONE: led_idle_o = 1. start_rise moves to IDLE.
- ERROR: led_err_o = 1. start_rise moves to IDLE.
- Abort: abort_i in ARMED, FRAME_RUN, FETCH or CORE moves to IDLE.
- Priority in running states: abort > done pulse > watchdog timeout.
- Watchdog:
  - The counter clears on every state transition and increments in FRAME_RUN, FETCH and CORE.
  - Reaching TIMEOUT_CYC-1 with no done pulse moves to ERROR.
- Done pulses arriving in a non-matching state are ignored.
- Widths: cnt_len products are computed at elaboration. A constant that does not fit LEN_W is a fatal elaboration error.

## Timing
- Reset (rst_n low at a clk edge):
  - state = IDLE; mode, row, start_q and watchdog = 0.
  - All outputs 0, state_o = 0.
- Run/len/LED/armed outputs are Moore outputs decoded from the state register only, with no combinational input-to-output path.
- Latency:
  - Input event at edge k → state and outputs change after edge k+1.
  - start_rise needs start_i low at edge k-1 and high at edge k.
- Row loop: minimum 2 cycles per row (FETCH and CORE, 1 cycle each).
- row_o updates on the same edge as the CORE→FETCH transition.
- Holding start_i high across DONE→IDLE→ARMED does not auto-start; a new rising edge is required.
- Reset asserted mid-run returns to IDLE at the next edge, regardless of done or abort inputs.

## Structure
- Package multimode_ctrl_pkg holds the state enum (3-bit typedef) and length-calculation functions.
- Sub-module ctrl_watchdog (parameters TIMEOUT_CYC; ports clr, en, expired) implements the timeout counter.
- All other logic stays in multimode_ctrl.

## Test plan
- Frame mode: mode_sel=0001, start pulse → FRAME_RUN with cnt_len_o=583200; frame_done → DONE with led_idle_o=1; start → IDLE.
- Row loop: mode_sel=0010, start; answer every fetch_done/core_done after 1 cycle → row_o counts 0..359, FETCH cnt_len_o=1620, DONE after 360th core_done, 720 running cycles.
- Re-select and invalid select: in ARMED, mode_sel 0010→0100 → mode_o=2; mode_sel=0110 → mode_o stays 2; start held high through DONE→IDLE → no restart.
- Abort and priority: abort_i and core_done_i in the same CORE cycle → IDLE and row unchanged; abort_i in FETCH → IDLE next cycle.
- Watchdog: TIMEOUT_CYC=16, never send fetch_done → ERROR after 16 cycles in FETCH with led_err_o=1; done and expiry on the same cycle → CORE.
- Reset: rst_n low at row 100 in CORE → IDLE, row_o=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/multimode_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the multimode image-pipeline sequencer.
package multimode_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArmed    = 3'd1,
    StFrameRun = 3'd2,
    StFetch    = 3'd3,
    StCore     = 3'd4,
    StDone     = 3'd5,
    StError    = 3'd6
  } state_e;

  function automatic longint unsigned frame_len(input longint unsigned rows,
                                                input longint unsigned cols,
                                                input longint unsigned bpp);
    return rows * cols * bpp;
  endfunction

  function automatic longint unsigned row_len(input longint unsigned cols,
                                              input longint unsigned bpp);
    return cols * bpp;
  endfunction

  function automatic bit fits_width(input longint unsigned val, input int unsigned width);
    return (width >= 64) || ((val >> width) == 0);
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Per-phase timeout counter: counts while enabled, flags the last allowed cycle.
module ctrl_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 2 ** 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LastCnt);

endmodule

// File: rtl/multimode_ctrl.sv
// Top-level sequencer: latches a one-hot mode, then runs either a whole-frame pass or a
// row-by-row FETCH/CORE loop, with start-edge detection, abort and a per-phase watchdog.
module multimode_ctrl
  import multimode_ctrl_pkg::*;
#(
  parameter int unsigned           NUM_MODES   = 4,
  parameter logic [NUM_MODES-1:0]  FRAME_MASK  = 4'b0001,
  parameter int unsigned           MAX_ROW     = 360,
  parameter int unsigned           MAX_COL     = 540,
  parameter int unsigned           BPP         = 3,
  parameter int unsigned           LEN_W       = 20,
  parameter int unsigned           ROW_W       = 10,
  parameter int unsigned           TIMEOUT_CYC = 2 ** 20,
  localparam int unsigned          ModeW       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_MODES-1:0] mode_sel_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 frame_done_i,
  input  logic                 fetch_done_i,
  input  logic                 core_done_i,
  output logic [ModeW-1:0]     mode_o,
  output logic                 armed_o,
  output logic                 frame_run_o,
  output logic                 fetch_run_o,
  output logic                 core_run_o,
  output logic [LEN_W-1:0]     cnt_len_o,
  output logic [ROW_W-1:0]     row_o,
  output logic                 led_idle_o,
  output logic                 led_err_o,
  output logic [2:0]           state_o
);

  localparam longint unsigned FrameLen = frame_len(MAX_ROW, MAX_COL, BPP);
  localparam longint unsigned RowLen   = row_len(MAX_COL, BPP);
  localparam logic [LEN_W-1:0] FrameLenW = LEN_W'(FrameLen);
  localparam logic [LEN_W-1:0] RowLenW   = LEN_W'(RowLen);
  localparam logic [ROW_W-1:0] LastRow   = ROW_W'(MAX_ROW - 1);

  if (!fits_width(FrameLen, LEN_W) || !fits_width(RowLen, LEN_W)) begin : g_len_check
    $fatal(1, "multimode_ctrl: transfer length constant does not fit LEN_W");
  end

  state_e           state_q, state_d;
  logic [ModeW-1:0] mode_q, mode_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             start_q;
  logic             armed_q, frame_run_q, fetch_run_q, core_run_q, led_idle_q, led_err_q;
  logic [LEN_W-1:0] cnt_len_q;

  logic             start_rise;
  logic             sel_valid;
  logic [ModeW-1:0] sel_idx;
  logic             running;
  logic             wd_expired;

  assign start_rise = start_i & ~start_q;
  assign sel_valid  = $onehot(mode_sel_i);
  assign running    = (state_q == StFrameRun) || (state_q == StFetch) || (state_q == StCore);

  always_comb begin
    sel_idx = '0;
    for (int unsigned m = 0; m < NUM_MODES; m++) begin
      if (mode_sel_i[m]) sel_idx = ModeW'(m);
    end
  end

  // Any state change restarts the timeout, so each phase gets the full budget.
  ctrl_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_d != state_q),
    .en     (running),
    .expired(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          mode_d  = sel_idx;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (start_rise) begin
          if (FRAME_MASK[mode_q]) begin
            state_d = StFrameRun;
          end else begin
            state_d = StFetch;
            row_d   = '0;
          end
        end else if (sel_valid) begin
          mode_d = sel_idx;
        end
      end
      StFrameRun: begin
        if (abort_i)           state_d = StIdle;
        else if (frame_done_i) state_d = StDone;
        else if (wd_expired)   state_d = StError;
      end
      StFetch: begin
        if (abort_i)           state_d = StIdle;
        else if (fetch_done_i) state_d = StCore;
        else if (wd_expired)   state_d = StError;
      end
      StCore: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (core_done_i) begin
          if (row_q == LastRow) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StFetch;
          end
        end else if (wd_expired) begin
          state_d = StError;
        end
      end
      StDone, StError: begin
        if (start_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      row_q       <= '0;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      frame_run_q <= 1'b0;
      fetch_run_q <= 1'b0;
      core_run_q  <= 1'b0;
      led_idle_q  <= 1'b0;
      led_err_q   <= 1'b0;
      cnt_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      start_q     <= start_i;
      armed_q     <= (state_d == StArmed);
      frame_run_q <= (state_d == StFrameRun);
      fetch_run_q <= (state_d == StFetch);
      core_run_q  <= (state_d == StCore);
      led_idle_q  <= (state_d == StDone);
      led_err_q   <= (state_d == StError);
      cnt_len_q   <= (state_d == StFrameRun) ? FrameLenW :
                     (state_d == StFetch)    ? RowLenW   : '0;
    end
  end

  assign mode_o      = mode_q;
  assign row_o       = row_q;
  assign state_o     = state_q;
  assign armed_o     = armed_q;
  assign frame_run_o = frame_run_q;
  assign fetch_run_o = fetch_run_q;
  assign core_run_o  = core_run_q;
  assign led_idle_o  = led_idle_q;
  assign led_err_o   = led_err_q;
  assign cnt_len_o   = cnt_len_q;

endmodule

// File: tb/tb_multimode_ctrl.sv
// Scoreboard bench for multimode_ctrl: expectations are queued with each stimulus cycle and
// checked one clock later.
module tb_multimode_ctrl;

  localparam int unsigned Tmo = 16;

  localparam int SigState = 0;
  localparam int SigMode  = 1;
  localparam int SigArmed = 2;
  localparam int SigFrame = 3;
  localparam int SigFetch = 4;
  localparam int SigCore  = 5;
  localparam int SigLen   = 6;
  localparam int SigRow   = 7;
  localparam int SigIdle  = 8;
  localparam int SigErr   = 9;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mode_sel;
  logic        start, abort, frame_done, fetch_done, core_done;
  logic [1:0]  mode;
  logic        armed, frame_run, fetch_run, core_run, led_idle, led_err;
  logic [19:0] cnt_len;
  logic [9:0]  row;
  logic [2:0]  state;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   run_cycles;

  always #5 clk = ~clk;

  multimode_ctrl #(
    .TIMEOUT_CYC(Tmo)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_sel_i  (mode_sel),
    .start_i     (start),
    .abort_i     (abort),
    .frame_done_i(frame_done),
    .fetch_done_i(fetch_done),
    .core_done_i (core_done),
    .mode_o      (mode),
    .armed_o     (armed),
    .frame_run_o (frame_run),
    .fetch_run_o (fetch_run),
    .core_run_o  (core_run),
    .cnt_len_o   (cnt_len),
    .row_o       (row),
    .led_idle_o  (led_idle),
    .led_err_o   (led_err),
    .state_o     (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_sig(input int sig);
    case (sig)
      SigState: return 32'(state);
      SigMode:  return 32'(mode);
      SigArmed: return 32'(armed);
      SigFrame: return 32'(frame_run);
      SigFetch: return 32'(fetch_run);
      SigCore:  return 32'(core_run);
      SigLen:   return 32'(cnt_len);
      SigRow:   return 32'(row);
      SigIdle:  return 32'(led_idle);
      SigErr:   return 32'(led_err);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, get_sig(e.sig), e.val);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; mode_sel = '0; start = 0; abort = 0;
    frame_done = 0; fetch_done = 0; core_done = 0;
    step();
    expect_sig("rst_state", SigState, 0);
    expect_sig("rst_row", SigRow, 0);
    expect_sig("rst_len", SigLen, 0);
    expect_sig("rst_idle", SigIdle, 0);
    expect_sig("rst_err", SigErr, 0);
    expect_sig("rst_armed", SigArmed, 0);
    step();

    // Whole-frame mode
    rst_n = 1'b1; mode_sel = 4'b0001;
    expect_sig("fr_armed_state", SigState, 1);
    expect_sig("fr_armed", SigArmed, 1);
    expect_sig("fr_mode", SigMode, 0);
    step();
    start = 1;
    expect_sig("fr_run_state", SigState, 2);
    expect_sig("fr_run", SigFrame, 1);
    expect_sig("fr_len", SigLen, 583200);
    step();
    start = 0;
    expect_sig("fr_still_run", SigState, 2);
    step();
    frame_done = 1;
    expect_sig("fr_done_state", SigState, 5);
    expect_sig("fr_done_led", SigIdle, 1);
    expect_sig("fr_done_len", SigLen, 0);
    step();
    frame_done = 0; start = 1; mode_sel = '0;
    expect_sig("fr_back_idle", SigState, 0);
    expect_sig("fr_idle_led", SigIdle, 0);
    step();
    start = 0;
    expect_sig("idle_no_sel", SigState, 0);
    step();

    // Re-select and invalid select
    mode_sel = 4'b0010;
    expect_sig("sel1", SigMode, 1);
    step();
    mode_sel = 4'b0100;
    expect_sig("resel2", SigMode, 2);
    expect_sig("resel_state", SigState, 1);
    step();
    mode_sel = 4'b0110;
    expect_sig("invalid_sel", SigMode, 2);
    step();
    mode_sel = 4'b0010;
    expect_sig("resel1", SigMode, 1);
    step();

    // Row loop, every done answered in the first cycle of its phase
    start = 1;
    expect_sig("rl_fetch", SigState, 3);
    expect_sig("rl_len", SigLen, 1620);
    expect_sig("rl_row0", SigRow, 0);
    step();
    run_cycles = (fetch_run | core_run) ? 1 : 0;
    start = 0;
    for (int r = 0; r < 360; r++) begin
      fetch_done = 1;
      expect_sig("rl_core", SigState, 4);
      expect_sig("rl_core_row", SigRow, 32'(r));
      step();
      if (fetch_run | core_run) run_cycles++;
      fetch_done = 0; core_done = 1;
      if (r < 359) begin
        expect_sig("rl_next_fetch", SigState, 3);
        expect_sig("rl_next_row", SigRow, 32'(r + 1));
        expect_sig("rl_next_len", SigLen, 1620);
      end else begin
        expect_sig("rl_done", SigState, 5);
        expect_sig("rl_done_row", SigRow, 359);
        expect_sig("rl_done_led", SigIdle, 1);
      end
      step();
      if (fetch_run | core_run) run_cycles++;
      core_done = 0;
    end
    check_eq("rl_run_cycles", 32'(run_cycles), 720);

    // Start held high across DONE -> IDLE -> ARMED must not auto-start
    start = 1;
    expect_sig("hold_idle", SigState, 0);
    step();
    expect_sig("hold_armed", SigState, 1);
    step();
    expect_sig("hold_no_start", SigState, 1);
    step();
    start = 0;
    expect_sig("hold_release", SigState, 1);
    step();

    // Abort beats done in CORE
    start = 1;
    expect_sig("ab_fetch", SigState, 3);
    step();
    start = 0; fetch_done = 1;
    step();
    fetch_done = 0; core_done = 1;
    expect_sig("ab_row1", SigRow, 1);
    step();
    core_done = 0; fetch_done = 1;
    expect_sig("ab_core", SigState, 4);
    step();
    fetch_done = 0; core_done = 1; abort = 1;
    expect_sig("ab_prio_idle", SigState, 0);
    expect_sig("ab_prio_row", SigRow, 1);
    step();
    core_done = 0; abort = 0;
    expect_sig("ab_rearm", SigState, 1);
    step();
    start = 1;
    step();
    start = 0; abort = 1;
    expect_sig("ab_fetch_idle", SigState, 0);
    expect_sig("ab_fetch_run", SigFetch, 0);
    step();
    abort = 0;
    step();

    // Watchdog expiry in FETCH
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 15; i++) begin
      expect_sig("wd_wait", SigState, 3);
      step();
    end
    expect_sig("wd_error", SigState, 6);
    expect_sig("wd_led", SigErr, 1);
    step();
    start = 1;
    expect_sig("wd_clear", SigState, 0);
    expect_sig("wd_led_off", SigErr, 0);
    step();
    start = 0;
    step();

    // Done on the expiry cycle wins
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 14; i++) step();
    expect_sig("wd_edge_wait", SigState, 3);
    step();
    fetch_done = 1;
    expect_sig("wd_done_wins", SigState, 4);
    expect_sig("wd_done_noerr", SigErr, 0);
    step();
    fetch_done = 0; abort = 1;
    step();
    abort = 0;
    step();

    // Synchronous reset in CORE at row 100
    start = 1;
    step();
    start = 0;
    for (int r = 0; r < 100; r++) begin
      fetch_done = 1;
      step();
      fetch_done = 0; core_done = 1;
      step();
      core_done = 0;
    end
    fetch_done = 1;
    expect_sig("rs_core", SigState, 4);
    expect_sig("rs_row100", SigRow, 100);
    step();
    fetch_done = 0; rst_n = 0; core_done = 1; abort = 1;
    expect_sig("rs_state", SigState, 0);
    expect_sig("rs_row", SigRow, 0);
    expect_sig("rs_mode", SigMode, 0);
    expect_sig("rs_core_run", SigCore, 0);
    expect_sig("rs_len", SigLen, 0);
    step();
    rst_n = 1; core_done = 0; abort = 0; mode_sel = '0;
    expect_sig("rs_stay_idle", SigState, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
